tcm_cycle_sched: RTL and testbench

- Machine-cycle scheduler for the TCM bus.
- Divides sysclk into a fixed 6-state machine cycle (S1..S6) of PPS phases each.
- Arbitrates one bus access per machine cycle between the instruction-fetch and data requesters.
- Drives the bus timing outputs ale, ps1, rd_n, wr_n and the latched address rmuadd toward the external memory interface.

---
 rtl/tcm_cycle_sched_pkg.sv | 12 +
 rtl/tcm_cycle_sched_if.sv | 27 ++
 rtl/tcm_cycle_sched_timebase.sv | 30 +++
 rtl/tcm_cycle_sched.sv | 73 +++++++
 tb/tb_tcm_cycle_sched.sv | 125 ++++++++++++
 5 files changed

// File: rtl/tcm_cycle_sched_pkg.sv
// tcm_pkg: shared types and constants for the TCM machine-cycle scheduler.
//   owner_t    : which requester owns the current machine cycle
//   NUM_STATES : states per machine cycle (S1..S6)
//   S_*        : state numbers bounding the ale and strobe windows
package tcm_pkg;
  typedef enum logic [1:0] {NONE, FETCH, DATA} owner_t;
  localparam logic [2:0] NUM_STATES  = 3'd6;
  localparam logic [2:0] S_ALE       = 3'd1;
  localparam logic [2:0] S_ALE2      = 3'd4;
  localparam logic [2:0] S_STB_FIRST = 3'd3;
  localparam logic [2:0] S_STB_LAST  = 3'd5;
endpackage

// File: rtl/tcm_cycle_sched_if.sv
// tcm_cycle_sched_if: request/grant and bus-timing bundle of the scheduler.
//   master : requester side (drives requests, sees grants and bus timing)
//   slave  : scheduler side
interface tcm_cycle_sched_if #(parameter int ADDR_W = 16);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic              data_we;
  logic              fetch_gnt;
  logic              data_gnt;
  logic              ale;
  logic              ps1;
  logic              rd_n;
  logic              wr_n;
  logic [ADDR_W-1:0] rmuadd;
  logic              cyc_done;
  logic [2:0]        state_idx;
  modport master (
    output fetch_req, fetch_addr, data_req, data_addr, data_we,
    input  fetch_gnt, data_gnt, ale, ps1, rd_n, wr_n, rmuadd, cyc_done, state_idx
  );
  modport slave (
    input  fetch_req, fetch_addr, data_req, data_addr, data_we,
    output fetch_gnt, data_gnt, ale, ps1, rd_n, wr_n, rmuadd, cyc_done, state_idx
  );
endinterface

// File: rtl/tcm_cycle_sched_timebase.sv
// tcm_timebase: free-running phase (0..PPS-1) and state (1..6) counters.
//   sysclk, por            : clock, synchronous active-high reset
//   state, phase           : current counter values
//   cycle_start, cycle_end : decode of S1/phase 0 and S6/phase PPS-1
module tcm_timebase
  import tcm_pkg::*;
#(
  parameter int PPS = 2
) (
  input  logic       sysclk,
  input  logic       por,
  output logic [2:0] state,
  output logic [2:0] phase,
  output logic       cycle_start,
  output logic       cycle_end
);
  logic last_phase;
  assign last_phase  = phase == 3'(PPS - 1);
  assign cycle_start = state == 3'd1 && phase == 3'd0;
  assign cycle_end   = state == NUM_STATES && last_phase;
  always_ff @(posedge sysclk) begin
    if (por) begin
      phase <= 3'd0;
      state <= 3'd1;
    end else begin
      phase <= last_phase ? 3'd0 : phase + 3'd1;
      state <= !last_phase ? state : state == NUM_STATES ? 3'd1 : state + 3'd1;
    end
  end
endmodule

// File: rtl/tcm_cycle_sched.sv
// tcm_cycle_sched: TCM bus machine-cycle scheduler with round-robin arbitration.
//   sysclk, por : clock, synchronous active-high reset
//   bus (slave) : fetch/data requests, grant pulses, ale/ps1/rd_n/wr_n strobes,
//                 rmuadd, cyc_done, state_idx
//   TCM_DUAL_ALE_EN : when defined, a second ale pulse in S4/S5 and ale in idle cycles
module tcm_cycle_sched
  import tcm_pkg::*;
#(
  parameter int PPS    = 2,
  parameter int ADDR_W = 16
) (
  input  logic                  sysclk,
  input  logic                  por,
  tcm_cycle_sched_if.slave      bus
);
  logic [2:0]        state, phase;
  logic              cycle_start, cycle_end;
  owner_t            owner, owner_nx, last, last_nx, win;
  logic              we;
  logic [ADDR_W-1:0] win_addr;
  logic              ale_win, stb_win, ale_d;
  tcm_timebase #(.PPS(PPS)) u_tb (
    .sysclk(sysclk), .por(por), .state(state), .phase(phase),
    .cycle_start(cycle_start), .cycle_end(cycle_end)
  );
  // Fetch wins a tie only when data was the last one served.
  always_comb begin
    win      = bus.fetch_req && (!bus.data_req || last == DATA) ? FETCH :
               bus.data_req ? DATA : NONE;
    win_addr = win == FETCH ? bus.fetch_addr : bus.data_addr;
    owner_nx = cycle_start ? win : cycle_end ? NONE : owner;
    last_nx  = cycle_start && win != NONE ? win : last;
  end
  assign ale_win = (state == S_ALE && phase != 3'd0) || (state == S_ALE + 3'd1 && phase == 3'd0);
  assign stb_win = state >= S_STB_FIRST && state <= S_STB_LAST;
`ifdef TCM_DUAL_ALE_EN
  logic ale2_win;
  assign ale2_win = (state == S_ALE2 && phase != 3'd0) || (state == S_ALE2 + 3'd1 && phase == 3'd0);
  assign ale_d    = ale_win || ale2_win;
`else
  assign ale_d    = owner != NONE && ale_win;
`endif
  assign bus.state_idx = state;
  always_ff @(posedge sysclk) begin
    if (por) begin
      owner         <= NONE;
      last          <= DATA;
      we            <= 1'b0;
      bus.fetch_gnt <= 1'b0;
      bus.data_gnt  <= 1'b0;
      bus.ale       <= 1'b0;
      bus.ps1       <= 1'b0;
      bus.rd_n      <= 1'b1;
      bus.wr_n      <= 1'b1;
      bus.rmuadd    <= '0;
      bus.cyc_done  <= 1'b0;
    end else begin
      owner         <= owner_nx;
      last          <= last_nx;
      bus.fetch_gnt <= cycle_start && win == FETCH;
      bus.data_gnt  <= cycle_start && win == DATA;
      if (cycle_start && win != NONE) begin
        bus.rmuadd <= win_addr;
        we         <= win == DATA && bus.data_we;
      end
      bus.ale       <= ale_d;
      bus.ps1       <= owner == FETCH && stb_win;
      bus.rd_n      <= !(owner == DATA && !we && stb_win);
      bus.wr_n      <= !(owner == DATA && we && stb_win);
      bus.cyc_done  <= cycle_end;
    end
  end
endmodule

// File: tb/tb_tcm_cycle_sched.sv
// tb_tcm_cycle_sched: directed bench for tcm_cycle_sched with PPS=2, ADDR_W=16.
module tb_tcm_cycle_sched;
  logic        sysclk = 1'b0;
  logic        por = 1'b1;
  int          total = 0;
  int          bad = 0;
  logic [11:0] fg, dg, al, p1, rn, wn, cd;
  logic [2:0]  st_mid;
`ifdef TCM_DUAL_ALE_EN
  localparam logic [15:0] ALE_G = 16'h186;
  localparam logic [15:0] ALE_I = 16'h186;
`else
  localparam logic [15:0] ALE_G = 16'h006;
  localparam logic [15:0] ALE_I = 16'h000;
`endif
  tcm_cycle_sched_if #(.ADDR_W(16)) bus ();
  tcm_cycle_sched #(.PPS(2), .ADDR_W(16)) dut (.sysclk(sysclk), .por(por), .bus(bus));
  always #5 sysclk = ~sysclk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask
  // Bit k of each vector holds the output seen k+1 clocks after the cycle-start clock.
  task automatic cap(input logic late_f);
    for (int k = 0; k < 12; k++) begin
      step();
      fg[k] = bus.fetch_gnt;
      dg[k] = bus.data_gnt;
      al[k] = bus.ale;
      p1[k] = bus.ps1;
      rn[k] = bus.rd_n;
      wn[k] = bus.wr_n;
      cd[k] = bus.cyc_done;
      if (k == 5) st_mid = bus.state_idx;
      if (late_f && k == 0) bus.fetch_req = 1'b1;
    end
  endtask
  task automatic chk_cyc(input string tag, input logic [15:0] efg, input logic [15:0] edg,
                         input logic [15:0] eal, input logic [15:0] ep1,
                         input logic [15:0] ern, input logic [15:0] ewn);
    chk({tag, ".fetch_gnt"}, 16'(fg), efg);
    chk({tag, ".data_gnt"}, 16'(dg), edg);
    chk({tag, ".ale"}, 16'(al), eal);
    chk({tag, ".ps1"}, 16'(p1), ep1);
    chk({tag, ".rd_n"}, 16'(rn), ern);
    chk({tag, ".wr_n"}, 16'(wn), ewn);
    chk({tag, ".cyc_done"}, 16'(cd), 16'h800);
    chk({tag, ".state_mid"}, 16'(st_mid), 16'd4);
    chk({tag, ".state_end"}, 16'(bus.state_idx), 16'd1);
  endtask
  initial begin
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.data_req = 1'b0; bus.data_addr = '0; bus.data_we = 1'b0;
    step();
    chk("rst.fetch_gnt", 16'(bus.fetch_gnt), 16'd0);
    chk("rst.data_gnt", 16'(bus.data_gnt), 16'd0);
    chk("rst.ale", 16'(bus.ale), 16'd0);
    chk("rst.ps1", 16'(bus.ps1), 16'd0);
    chk("rst.rd_n", 16'(bus.rd_n), 16'd1);
    chk("rst.wr_n", 16'(bus.wr_n), 16'd1);
    chk("rst.rmuadd", bus.rmuadd, 16'h0000);
    chk("rst.cyc_done", 16'(bus.cyc_done), 16'd0);
    chk("rst.state", 16'(bus.state_idx), 16'd1);
    por = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'h1234;
    cap(1'b0);
    chk_cyc("fetch", 16'h001, 16'h000, ALE_G, 16'h3F0, 16'hFFF, 16'hFFF);
    chk("fetch.rmuadd", bus.rmuadd, 16'h1234);
    bus.fetch_req = 1'b0;
    bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 16'h00A5;
    cap(1'b0);
    chk_cyc("dwr", 16'h000, 16'h001, ALE_G, 16'h000, 16'hFFF, 16'hC0F);
    chk("dwr.rmuadd", bus.rmuadd, 16'h00A5);
    bus.data_we = 1'b0; bus.data_addr = 16'h0BEE;
    cap(1'b0);
    chk_cyc("drd", 16'h000, 16'h001, ALE_G, 16'h000, 16'hC0F, 16'hFFF);
    chk("drd.rmuadd", bus.rmuadd, 16'h0BEE);
    bus.data_req = 1'b0;
    cap(1'b1);
    chk_cyc("idle", 16'h000, 16'h000, ALE_I, 16'h000, 16'hFFF, 16'hFFF);
    chk("idle.rmuadd", bus.rmuadd, 16'h0BEE);
    bus.fetch_addr = 16'h5A5A;
    cap(1'b0);
    chk_cyc("late", 16'h001, 16'h000, ALE_G, 16'h3F0, 16'hFFF, 16'hFFF);
    chk("late.rmuadd", bus.rmuadd, 16'h5A5A);
    // Previous grant was FETCH; reset must restore last=DATA so fetch wins the first tie.
    por = 1'b1;
    step();
    por = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'h1111;
    bus.data_req = 1'b1; bus.data_addr = 16'h2222; bus.data_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cap(1'b0);
      chk($sformatf("tie%0d.fetch_gnt", i), 16'(fg), i % 2 == 0 ? 16'h001 : 16'h000);
      chk($sformatf("tie%0d.data_gnt", i), 16'(dg), i % 2 == 0 ? 16'h000 : 16'h001);
      chk($sformatf("tie%0d.rmuadd", i), bus.rmuadd, i % 2 == 0 ? 16'h1111 : 16'h2222);
    end
    bus.data_req = 1'b0;
    bus.fetch_addr = 16'h7777;
    for (int i = 0; i < 7; i++) step();
    chk("mid.ps1", 16'(bus.ps1), 16'd1);
    chk("mid.state", 16'(bus.state_idx), 16'd4);
    chk("mid.rmuadd", bus.rmuadd, 16'h7777);
    por = 1'b1;
    step();
    chk("abort.ps1", 16'(bus.ps1), 16'd0);
    chk("abort.state", 16'(bus.state_idx), 16'd1);
    chk("abort.rmuadd", bus.rmuadd, 16'h0000);
    chk("abort.ale", 16'(bus.ale), 16'd0);
    por = 1'b0;
    bus.fetch_req = 1'b0;
    cap(1'b0);
    chk_cyc("clean", 16'h000, 16'h000, ALE_I, 16'h000, 16'hFFF, 16'hFFF);
    chk("clean.rmuadd", bus.rmuadd, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
